seg_display_ctrl: RTL



---
 rtl/seg_display_pkg.sv | 38 +++
 rtl/seg_display_ctrl_if.sv | 24 ++
 rtl/seg_display_ctrl_bin2bcd.sv | 25 ++
 rtl/seg_display_ctrl.sv | 97 +++++++++
 4 files changed

// File: rtl/seg_display_pkg.sv
// rtl/seg_display_pkg.sv - segment codes and decode helper for the 4-digit scan controller
package seg_display_pkg;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

    localparam logic [13:0] MAX_DISPLAY = 14'd9999;

    // Active-low {g,f,e,d,c,b,a}; non-decimal codes come out dark.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = SEG_0;
            4'd1:    s = SEG_1;
            4'd2:    s = SEG_2;
            4'd3:    s = SEG_3;
            4'd4:    s = SEG_4;
            4'd5:    s = SEG_5;
            4'd6:    s = SEG_6;
            4'd7:    s = SEG_7;
            4'd8:    s = SEG_8;
            4'd9:    s = SEG_9;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg_display_ctrl_if.sv
// rtl/seg_display_ctrl_if.sv - value load and display pin bundle for seg_display_ctrl
interface seg_display_ctrl_if;
    logic [13:0] value;
    logic        load;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        ovf;

    modport master (
        output value,
        output load,
        input  an,
        input  seg,
        input  ovf
    );

    modport slave (
        input  value,
        input  load,
        output an,
        output seg,
        output ovf
    );
endinterface

// File: rtl/seg_display_ctrl_bin2bcd.sv
// rtl/seg_display_ctrl_bin2bcd.sv - combinational 14-bit binary to BCD (double dabble)
module bin2bcd (
    input  logic [13:0] bin,
    output logic [4:0]  thousands,
    output logic [3:0]  hundreds,
    output logic [3:0]  tens,
    output logic [3:0]  ones
);
    // Thousands column is never add-3 corrected, so it ends up as a plain binary count (0..16).
    logic [30:0] sr;

    always_comb begin
        sr = {17'd0, bin};
        for (int i = 0; i < 14; i++) begin
            if (sr[17:14] >= 4'd5) sr[17:14] = sr[17:14] + 4'd3;
            if (sr[21:18] >= 4'd5) sr[21:18] = sr[21:18] + 4'd3;
            if (sr[25:22] >= 4'd5) sr[25:22] = sr[25:22] + 4'd3;
            sr = sr << 1;
        end
        ones      = sr[17:14];
        tens      = sr[21:18];
        hundreds  = sr[25:22];
        thousands = sr[30:26];
    end
endmodule

// File: rtl/seg_display_ctrl.sv
// rtl/seg_display_ctrl.sv - 4-digit multiplexed common-anode 7-segment scan controller
module seg_display_ctrl
    import seg_display_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 50000,
    parameter bit          BLANK_LZ    = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    seg_display_ctrl_if.slave  bus
);
    localparam int unsigned    CNT_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

    logic [13:0]      value_q, value_d;
    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             ovf_q, ovf_d;

    logic [4:0] th;
    logic [3:0] hu, te, on;
    logic [3:0] digit;
    logic       blank;

    bin2bcd u_bin2bcd (
        .bin       (value_q),
        .thousands (th),
        .hundreds  (hu),
        .tens      (te),
        .ones      (on)
    );

    always_comb begin
        value_d   = bus.load ? bus.value : value_q;
        div_cnt_d = div_cnt_q + CNT_W'(1);
        idx_d     = idx_q;
        if (div_cnt_q == CNT_LAST) begin
            div_cnt_d = '0;
            idx_d     = idx_q + 2'd1;
        end

        // Outputs follow the pre-edge idx and value_q, giving one cycle of latency.
        an_d  = ~(4'b0001 << idx_q);
        ovf_d = (value_q > MAX_DISPLAY);

        digit = on;
        blank = 1'b0;
        case (idx_q)
            2'd0: begin
                digit = on;
                blank = 1'b0;
            end
            2'd1: begin
                digit = te;
                blank = (th == 5'd0) && (hu == 4'd0) && (te == 4'd0);
            end
            2'd2: begin
                digit = hu;
                blank = (th == 5'd0) && (hu == 4'd0);
            end
            default: begin
                digit = th[3:0];
                blank = (th == 5'd0);
            end
        endcase
        blank = blank && BLANK_LZ;

        if (ovf_d)      seg_d = SEG_DASH;
        else if (blank) seg_d = SEG_BLANK;
        else            seg_d = bcd_to_seg(digit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q   <= '0;
            div_cnt_q <= '0;
            idx_q     <= '0;
            an_q      <= 4'b1111;
            seg_q     <= SEG_BLANK;
            ovf_q     <= 1'b0;
        end else begin
            value_q   <= value_d;
            div_cnt_q <= div_cnt_d;
            idx_q     <= idx_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.an  = an_q;
    assign bus.seg = seg_q;
    assign bus.ovf = ovf_q;

endmodule
